slow_ddr3_traffic_gen: RTL and testbench

SLOW_DDR3_TRAFFIC_GEN -- requirements
Module: slow_ddr3_traffic_gen

---
 rtl/slow_ddr3_pkg.sv | 24 ++
 rtl/slow_ddr3_pattern_gen.sv | 35 +++
 rtl/slow_ddr3_traffic_gen.sv | 159 +++++++++++++++
 tb/tb_slow_ddr3_traffic_gen.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_ddr3_pkg.sv
// Shared types and constants for the slow DDR3 write/read-back traffic generator.
package slow_ddr3_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_e;

    localparam int unsigned PAT_W = 16;
    localparam int unsigned IDX_W = 17;

    localparam logic [1:0]       SEL_ALL   = 2'b11;
    localparam logic [PAT_W-1:0] LFSR_SEED = 16'hACE1;
    // Feedback taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
    localparam logic [PAT_W-1:0] LFSR_TAPS = 16'h002D;

    function automatic logic [PAT_W-1:0] lfsr_next(input logic [PAT_W-1:0] s);
        return {^(s & LFSR_TAPS), s[PAT_W-1:1]};
    endfunction

endpackage

// File: rtl/slow_ddr3_pattern_gen.sv
// Test pattern source: incrementing word, or LFSR when SLOW_DDR3_TRAFFIC_GEN_LFSR_EN is defined.
module slow_ddr3_pattern_gen
    import slow_ddr3_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    output logic [PAT_W-1:0] value
);

`ifdef SLOW_DDR3_TRAFFIC_GEN_LFSR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= LFSR_SEED;
        end else if (advance) begin
            value <= lfsr_next(value);
        end
    end
`else
    // Tracks index[15:0], so it stays in step with the word address
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= '0;
        end else if (advance) begin
            value <= value + PAT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/slow_ddr3_traffic_gen.sv
// Writes WORDS pattern words to the DDR3 user interface, reads them back and counts mismatches.
// Optional LFSR pattern: define SLOW_DDR3_TRAFFIC_GEN_LFSR_EN.
module slow_ddr3_traffic_gen
    import slow_ddr3_pkg::*;
#(
    parameter int unsigned WORDS  = 32768,
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sysIO_initFin,
    output logic              sysIO_dataWr_valid,
    input  logic              sysIO_dataWr_ready,
    output logic [DATA_W-1:0] sysIO_dataWr_payload,
    output logic              sysIO_dataRd_ready,
    input  logic              sysIO_dataRd_valid,
    input  logic [DATA_W-1:0] sysIO_dataRd_payload,
    output logic [ADDR_W-1:0] sysIO_address,
    output logic [1:0]        sysIO_sel,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    state_e           state_q;
    state_e           state_d;
    logic [IDX_W-1:0] index_q;
    logic [PAT_W-1:0] wr_value;
    logic [PAT_W-1:0] rd_expected;
    logic             clear_c;
    logic             wr_load_c;
    logic             rd_load_c;
    logic             wr_xfer_c;
    logic             rd_xfer_c;
    logic             last_c;
    logic             mismatch_c;

    assign last_c     = (index_q == IDX_W'(WORDS - 1));
    assign mismatch_c = rd_xfer_c && (sysIO_dataRd_payload != DATA_W'(rd_expected));

    assign sysIO_address        = ADDR_W'(index_q);
    assign sysIO_dataWr_payload = DATA_W'(wr_value);
    assign sysIO_sel            = SEL_ALL;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transfers only count in their own phase; stray handshakes elsewhere fall through
    always_comb begin
        state_d   = state_q;
        clear_c   = 1'b0;
        wr_load_c = 1'b0;
        rd_load_c = 1'b0;
        wr_xfer_c = 1'b0;
        rd_xfer_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_WAIT_INIT;
                    clear_c = 1'b1;
                end
            end
            ST_WAIT_INIT: begin
                if (sysIO_initFin) begin
                    state_d   = ST_WRITE;
                    wr_load_c = 1'b1;
                end
            end
            ST_WRITE: begin
                if (sysIO_dataWr_valid && sysIO_dataWr_ready) begin
                    wr_xfer_c = 1'b1;
                    if (last_c) begin
                        state_d   = ST_READ;
                        rd_load_c = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (sysIO_dataRd_valid && sysIO_dataRd_ready) begin
                    rd_xfer_c = 1'b1;
                    if (last_c) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (reset) begin
            sysIO_dataWr_valid <= 1'b0;
            sysIO_dataRd_ready <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            err_count          <= '0;
            first_err_addr     <= '0;
            index_q            <= '0;
        end else begin
            sysIO_dataWr_valid <= (state_d == ST_WRITE);
            sysIO_dataRd_ready <= (state_d == ST_READ);
            busy               <= (state_d == ST_WAIT_INIT) || (state_d == ST_WRITE) ||
                                  (state_d == ST_READ);
            if (clear_c) begin
                done           <= 1'b0;
                pass           <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
                index_q        <= '0;
            end
            if (wr_xfer_c) begin
                index_q <= last_c ? '0 : index_q + IDX_W'(1);
            end
            if (rd_xfer_c) begin
                index_q <= index_q + IDX_W'(1);
            end
            if (mismatch_c) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == '0) begin
                    first_err_addr <= ADDR_W'(index_q);
                end
            end
            if (rd_xfer_c && last_c) begin
                done <= 1'b1;
                pass <= (err_count == '0) && !mismatch_c;
            end
        end
    end

    slow_ddr3_pattern_gen u_wr_pattern (
        .clk     (clk),
        .reset   (reset),
        .load    (wr_load_c),
        .advance (wr_xfer_c),
        .value   (wr_value)
    );

    slow_ddr3_pattern_gen u_rd_pattern (
        .clk     (clk),
        .reset   (reset),
        .load    (rd_load_c),
        .advance (rd_xfer_c),
        .value   (rd_expected)
    );

endmodule

// File: tb/tb_slow_ddr3_traffic_gen.sv
// Bench for slow_ddr3_traffic_gen: controller model with memory, write scoreboard, status checks.
module tb_slow_ddr3_traffic_gen;

    localparam int unsigned ADDR_W = 27;
    localparam int unsigned DATA_W = 16;
`ifdef SLOW_DDR3_TRAFFIC_GEN_LFSR_EN
    localparam int unsigned WORDS = 4;
`else
    localparam int unsigned WORDS = 16;
`endif
    localparam int CORRUPT_ADDR = (WORDS > 5) ? 5 : 2;
    localparam int MID_ADDR     = (WORDS > 7) ? 7 : 2;
    localparam int BUDGET       = 600;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              init_fin = 1'b0;
    logic              wr_valid;
    logic              wr_ready = 1'b0;
    logic [DATA_W-1:0] wr_payload;
    logic              rd_ready;
    logic              rd_valid = 1'b0;
    logic [DATA_W-1:0] rd_payload = '0;
    logic [ADDR_W-1:0] address;
    logic [1:0]        sel;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    wr_exp_t           wr_q[$];
    wr_exp_t           exp_e;
    logic [DATA_W-1:0] mem [WORDS];
    bit                stall_en = 1'b0;
    bit                ready_ph = 1'b0;
    bit                corrupt_en = 1'b0;
    bit                junk_rd = 1'b0;
    bit                stalled = 1'b0;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    int                ai;

    slow_ddr3_traffic_gen #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .sysIO_initFin        (init_fin),
        .sysIO_dataWr_valid   (wr_valid),
        .sysIO_dataWr_ready   (wr_ready),
        .sysIO_dataWr_payload (wr_payload),
        .sysIO_dataRd_ready   (rd_ready),
        .sysIO_dataRd_valid   (rd_valid),
        .sysIO_dataRd_payload (rd_payload),
        .sysIO_address        (address),
        .sysIO_sel            (sel),
        .busy                 (busy),
        .done                 (done),
        .pass                 (pass),
        .err_count            (err_count),
        .first_err_addr       (first_err_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] exp_word(input int i);
`ifdef SLOW_DDR3_TRAFFIC_GEN_LFSR_EN
        case (i)
            0:       return 16'hACE1;
            1:       return 16'h5670;
            2:       return 16'hAB38;
            default: return 16'h559C;
        endcase
`else
        return DATA_W'(i);
`endif
    endfunction

    // Controller model: drives handshakes at negedge, checks every write against the scoreboard
    always @(negedge clk) begin
        ready_ph = ~ready_ph;
        wr_ready = stall_en ? ready_ph : 1'b1;
        if (stalled && wr_valid) begin
            n_cmp++;
            if (address !== st_addr || wr_payload !== st_data) begin
                n_mis++;
                $display("FAIL stall_hold: addr=%0h data=%h, required addr=%0h data=%h",
                         address, wr_payload, st_addr, st_data);
            end
        end
        stalled = (wr_valid === 1'b1) && !wr_ready;
        st_addr = address;
        st_data = wr_payload;
        ai      = int'(address);
        if (wr_valid === 1'b1 && wr_ready) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
                n_mis++;
                $display("FAIL wr_unexpected: addr=%0h data=%h, required no write", address, wr_payload);
            end else begin
                exp_e = wr_q.pop_front();
                if (address !== exp_e.addr || wr_payload !== exp_e.data) begin
                    n_mis++;
                    $display("FAIL wr_beat: addr=%0h data=%h, required addr=%0h data=%h",
                             address, wr_payload, exp_e.addr, exp_e.data);
                end
            end
            if (ai >= 0 && ai < int'(WORDS)) mem[ai] = wr_payload;
        end
        rd_valid = (rd_ready === 1'b1) || junk_rd;
        if (junk_rd) begin
            rd_payload = 16'hBAD0;
        end else if (ai >= 0 && ai < int'(WORDS)) begin
            rd_payload = (corrupt_en && ai == CORRUPT_ADDR) ? 16'hDEAD : mem[ai];
        end else begin
            rd_payload = '0;
        end
    end

    task automatic push_expected();
        wr_q.delete();
        for (int i = 0; i < int'(WORDS); i++) begin
            wr_q.push_back('{addr: ADDR_W'(i), data: exp_word(i)});
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({wr_valid, rd_ready, busy, done, pass} !== 5'b0 || err_count !== 16'd0 ||
            first_err_addr !== '0 || address !== '0 || wr_payload !== '0) begin
            n_mis++;
            $display("FAIL reset_outputs: valid=%b ready=%b busy=%b done=%b pass=%b err=%0d first=%0h addr=%0h data=%h, required all zero",
                     wr_valid, rd_ready, busy, done, pass, err_count, first_err_addr, address, wr_payload);
        end
        n_cmp++;
        if (sel !== 2'b11) begin
            n_mis++;
            $display("FAIL reset_sel: sel=%b, required 11", sel);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        bit early = 1'b0;
        push_expected();
        init_fin = 1'b0;
        junk_rd  = 1'b1;
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_mis++;
            $display("FAIL basic_busy: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        for (int c = 2; c < 50; c++) begin
            @(negedge clk);
            if (wr_valid !== 1'b0 || busy !== 1'b1) early = 1'b1;
        end
        n_cmp++;
        if (early) begin
            n_mis++;
            $display("FAIL basic_wait_init: write issued or busy dropped before initFin, required hold");
        end
        junk_rd  = 1'b0;
        init_fin = 1'b1;
        wait_done(ok);
        n_cmp++;
        if (!ok) begin
            n_mis++;
            $display("FAIL basic_timeout: done=%b, required 1 within %0d cycles", done, BUDGET);
        end
        n_cmp++;
        if (pass !== 1'b1 || err_count !== 16'd0 || busy !== 1'b0 || wr_q.size() != 0) begin
            n_mis++;
            $display("FAIL basic_status: pass=%b err=%0d busy=%b pending=%0d, required pass=1 err=0 busy=0 pending=0",
                     pass, err_count, busy, wr_q.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        push_expected();
        stall_en = 1'b1;
        pulse_start();
        wait_done(ok);
        stall_en = 1'b0;
        n_cmp++;
        if (!ok || pass !== 1'b1 || err_count !== 16'd0 || wr_q.size() != 0) begin
            n_mis++;
            $display("FAIL stall_status: done=%b pass=%b err=%0d pending=%0d, required done=1 pass=1 err=0 pending=0",
                     done, pass, err_count, wr_q.size());
        end
    endtask

    task automatic test_corrupt();
        bit ok;
        push_expected();
        corrupt_en = 1'b1;
        pulse_start();
        wait_done(ok);
        corrupt_en = 1'b0;
        n_cmp++;
        if (!ok || pass !== 1'b0 || err_count !== 16'd1) begin
            n_mis++;
            $display("FAIL corrupt_status: done=%b pass=%b err=%0d, required done=1 pass=0 err=1",
                     done, pass, err_count);
        end
        n_cmp++;
        if (first_err_addr !== ADDR_W'(CORRUPT_ADDR)) begin
            n_mis++;
            $display("FAIL corrupt_first_addr: first=%0h, required %0h", first_err_addr, CORRUPT_ADDR);
        end
    endtask

    task automatic test_rerun_clear();
        bit ok;
        push_expected();
        pulse_start();
        n_cmp++;
        if (done !== 1'b0 || pass !== 1'b0 || err_count !== 16'd0 || first_err_addr !== '0 || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL rerun_clear: done=%b pass=%b err=%0d first=%0h busy=%b, required 0/0/0/0/1",
                     done, pass, err_count, first_err_addr, busy);
        end
        wait_done(ok);
        n_cmp++;
        if (!ok || pass !== 1'b1 || err_count !== 16'd0) begin
            n_mis++;
            $display("FAIL rerun_status: done=%b pass=%b err=%0d, required 1/1/0", done, pass, err_count);
        end
    endtask

    task automatic test_start_in_read();
        bit ok;
        bit seen = 1'b0;
        push_expected();
        pulse_start();
        for (int c = 0; c < BUDGET && !seen; c++) begin
            @(negedge clk);
            if (rd_ready === 1'b1) seen = 1'b1;
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (!seen || rd_ready !== 1'b1 || busy !== 1'b1) begin
            n_mis++;
            $display("FAIL start_in_read: seen=%b rd_ready=%b busy=%b, required 1/1/1", seen, rd_ready, busy);
        end
        wait_done(ok);
        n_cmp++;
        if (!ok || pass !== 1'b1 || err_count !== 16'd0 || wr_q.size() != 0) begin
            n_mis++;
            $display("FAIL start_in_read_status: done=%b pass=%b err=%0d pending=%0d, required 1/1/0/0",
                     done, pass, err_count, wr_q.size());
        end
    endtask

    task automatic test_reset_mid_write();
        bit ok;
        bit seen = 1'b0;
        push_expected();
        pulse_start();
        for (int c = 0; c < BUDGET && !seen; c++) begin
            @(negedge clk);
            if (wr_valid === 1'b1 && address === ADDR_W'(MID_ADDR)) seen = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (!seen || busy !== 1'b0 || wr_valid !== 1'b0 || rd_ready !== 1'b0 ||
            address !== '0 || wr_payload !== '0 || sel !== 2'b11) begin
            n_mis++;
            $display("FAIL reset_mid_write: seen=%b busy=%b valid=%b ready=%b addr=%0h data=%h sel=%b, required 1/0/0/0/0/0/11",
                     seen, busy, wr_valid, rd_ready, address, wr_payload, sel);
        end
        push_expected();
        pulse_start();
        wait_done(ok);
        n_cmp++;
        if (!ok || pass !== 1'b1 || err_count !== 16'd0 || wr_q.size() != 0) begin
            n_mis++;
            $display("FAIL reset_rerun_status: done=%b pass=%b err=%0d pending=%0d, required 1/1/0/0",
                     done, pass, err_count, wr_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_corrupt();
        test_rerun_clear();
        test_start_in_read();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
